// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: releases NSTAGES dependent resources in order, with a timed
// reset pulse, bounded ready wait, retries and sticky fault. Optional: RSTSEQ_LOCK_MONITOR_EN.
module reset_sequencer #(
  parameter int NSTAGES   = 3,
  parameter int HOLD      = 128,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSTAGES-1:0] stage_ready,
  output logic [NSTAGES-1:0] stage_rst,
  output logic               sys_rst,
  output logic               seq_done,
  output logic               fault,
  output logic [2:0]         fault_stage,
  output logic [7:0]         retry_total
);

  localparam int CNT_MAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [2:0]    LAST_STAGE = 3'(NSTAGES - 1);
  localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_ASSERT = 2'b00,
    S_WAIT   = 2'b01,
    S_DONE   = 2'b10,
    S_FAULT  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cur_q, cur_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         tries_q, tries_d;
  logic [7:0]         retry_q, retry_d;
  logic [2:0]         fstage_q, fstage_d;
  logic [NSTAGES-1:0] stage_rst_q, stage_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               seq_done_q, seq_done_d;
  logic               fault_q, fault_d;
  logic [7:0]         ready_ext_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

`ifdef RSTSEQ_LOCK_MONITOR_EN
  function automatic logic [2:0] lowest_zero(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction
`endif

  // Unused upper lanes read as ready so they never trigger resequencing or index out of range
  always_comb begin
    ready_ext_s = 8'hFF;
    ready_ext_s[NSTAGES-1:0] = stage_ready;
  end

  // Sequencer next-state logic
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    tries_d  = tries_q;
    retry_d  = retry_q;
    fstage_d = fstage_q;
    case (state_q)
      S_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (ready_ext_s[cur_q]) begin
          cnt_d = '0;
          if (cur_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 3'd1;
            tries_d = 4'd0;
            state_d = S_ASSERT;
          end
        end else if (cnt_q == TO_LAST) begin
          cnt_d = '0;
          if (tries_q == RETRY_LIM) begin
            state_d  = S_FAULT;
            fstage_d = cur_q;
          end else begin
            tries_d = tries_q + 4'd1;
            retry_d = sat_inc8(retry_q);
            state_d = S_ASSERT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
`ifdef RSTSEQ_LOCK_MONITOR_EN
        if (!(&ready_ext_s)) begin
          state_d = S_ASSERT;
          cur_d   = lowest_zero(ready_ext_s);
          cnt_d   = '0;
          tries_d = 4'd0;
          retry_d = sat_inc8(retry_q);
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_ASSERT;
        cur_d   = 3'd0;
        cnt_d   = '0;
        tries_d = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop
  always_comb begin
    stage_rst_d = '0;
    sys_rst_d   = 1'b1;
    seq_done_d  = 1'b0;
    fault_d     = 1'b0;
    case (state_d)
      S_DONE: begin
        sys_rst_d  = 1'b0;
        seq_done_d = 1'b1;
      end
      S_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        fault_d = 1'b0;
      end
    endcase
    for (int i = 0; i < NSTAGES; i++) begin
      if (state_d == S_DONE) begin
        stage_rst_d[i] = 1'b0;
      end else if (3'(i) > cur_d) begin
        stage_rst_d[i] = 1'b1;
      end else if (3'(i) == cur_d) begin
        stage_rst_d[i] = (state_d == S_ASSERT) || (state_d == S_FAULT);
      end else begin
        stage_rst_d[i] = 1'b0;
      end
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ASSERT;
      cur_q    <= 3'd0;
      cnt_q    <= '0;
      tries_q  <= 4'd0;
      retry_q  <= 8'd0;
      fstage_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      tries_q  <= tries_d;
      retry_q  <= retry_d;
      fstage_q <= fstage_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_rst_q <= '1;
      sys_rst_q   <= 1'b1;
      seq_done_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      stage_rst_q <= stage_rst_d;
      sys_rst_q   <= sys_rst_d;
      seq_done_q  <= seq_done_d;
      fault_q     <= fault_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign sys_rst     = sys_rst_q;
  assign seq_done    = seq_done_q;
  assign fault       = fault_q;
  assign fault_stage = fstage_q;
  assign retry_total = retry_q;

endmodule
